// File: rtl/io_seq_counter.sv
// Programmable modulo counter on mprj_io[1:0], configured and observed through LA probes.
// A prescaler sets the count rate; an optional wrap limit ends the run after N full cycles.
module io_seq_counter #(
    parameter int PRESC_W = 8,
    parameter int WRAP_W  = 8,
    parameter int IO_PADS = 38
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [31:0]        la_data_in,
    input  logic [31:0]        la_oenb,
    output logic [31:0]        la_data_out,
    output logic [IO_PADS-1:0] io_out,
    output logic [IO_PADS-1:0] io_oeb
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [31:0]        la_in;
    logic               la_start;
    logic               la_stop;
    logic               la_step;
    logic [PRESC_W-1:0] la_div;
    logic [1:0]         la_top;
    logic [WRAP_W-1:0]  la_wrap_limit;

    logic               start_q;
    logic               stop_q;
    logic               step_q;
    logic               start_edge;
    logic               stop_edge;
    logic               step_edge;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [1:0]         count_q;
    logic [1:0]         count_d;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic [WRAP_W-1:0]  wrap_cnt_q;
    logic [WRAP_W-1:0]  wrap_cnt_d;
    logic [WRAP_W-1:0]  wrap_inc;
    logic [PRESC_W-1:0] div_q;
    logic [PRESC_W-1:0] div_d;
    logic [1:0]         top_q;
    logic [1:0]         top_d;
    logic [WRAP_W-1:0]  wrap_limit_q;
    logic [WRAP_W-1:0]  wrap_limit_d;
    logic               done_q;
    logic               tick;

    // Bits not driven by the management core read as zero.
    assign la_in         = la_data_in & ~la_oenb;
    assign la_start      = la_in[0];
    assign la_stop       = la_in[1];
    assign la_step       = la_in[2];
    assign la_div        = la_in[8 +: PRESC_W];
    assign la_top        = la_in[17:16];
    assign la_wrap_limit = la_in[20 +: WRAP_W];

    assign start_edge = la_start & ~start_q;
    assign stop_edge  = la_stop  & ~stop_q;
    assign step_edge  = la_step  & ~step_q;

    assign tick     = (presc_q == div_q);
    assign wrap_inc = wrap_cnt_q + 1'b1;

    // Edge registers keep loading during reset so a level held across reset is not an edge.
    always_ff @(posedge wb_clk_i) begin
        start_q <= la_start;
        stop_q  <= la_stop;
        step_q  <= la_step;
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        presc_d      = presc_q;
        wrap_cnt_d   = wrap_cnt_q;
        div_d        = div_q;
        top_d        = top_q;
        wrap_limit_d = wrap_limit_q;
        case (state_q)
            ST_IDLE: begin
                if (stop_edge) begin
                    presc_d = '0;
                end else if (start_edge) begin
                    state_d      = ST_RUN;
                    presc_d      = '0;
                    wrap_cnt_d   = '0;
                    div_d        = la_div;
                    top_d        = la_top;
                    wrap_limit_d = la_wrap_limit;
                end else if (step_edge) begin
                    count_d = (count_q >= la_top) ? 2'd0 : count_q + 2'd1;
                end
            end
            ST_RUN: begin
                if (stop_edge) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else if (tick) begin
                    presc_d = '0;
                    // >= also folds a count left above top (carried in from IDLE) back to 0.
                    if (count_q >= top_q) begin
                        count_d    = 2'd0;
                        wrap_cnt_d = (&wrap_cnt_q) ? wrap_cnt_q : wrap_inc;
                        if ((wrap_limit_q != '0) && (wrap_inc == wrap_limit_q)) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        count_d = count_q + 2'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (stop_edge) begin
                    state_d = ST_IDLE;
                end else if (start_edge) begin
                    state_d      = ST_RUN;
                    count_d      = 2'd0;
                    presc_d      = '0;
                    wrap_cnt_d   = '0;
                    div_d        = la_div;
                    top_d        = la_top;
                    wrap_limit_d = la_wrap_limit;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            count_q      <= 2'd0;
            presc_q      <= '0;
            wrap_cnt_q   <= '0;
            div_q        <= '0;
            top_q        <= 2'd0;
            wrap_limit_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            presc_q      <= presc_d;
            wrap_cnt_q   <= wrap_cnt_d;
            div_q        <= div_d;
            top_q        <= top_d;
            wrap_limit_q <= wrap_limit_d;
            done_q       <= (state_d == ST_DONE);
        end
    end

    // Outputs are direct register taps; only pads 1:0 are ever driven.
    always_comb begin
        io_out      = '0;
        io_out[1:0] = count_q;
        io_oeb      = '1;
        io_oeb[1:0] = 2'b00;
    end

    always_comb begin
        la_data_out                 = '0;
        la_data_out[1:0]            = count_q;
        la_data_out[3:2]            = state_q;
        la_data_out[4]              = done_q;
        la_data_out[8 +: WRAP_W]    = wrap_cnt_q;
    end

endmodule

// File: tb/tb_io_seq_counter.sv
// Directed bench for io_seq_counter: LA control words are built by hand and every
// expected count/state/wrap value is worked out from the cycle timing of the counter.
module tb_io_seq_counter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [31:0] la_data_in;
    logic [31:0] la_oenb;
    logic [31:0] la_data_out;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] exp_q[$];

    io_seq_counter #(.PRESC_W(8), .WRAP_W(8), .IO_PADS(38)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .io_out      (io_out),
        .io_oeb      (io_oeb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input bit st, input bit sp, input bit sep,
                                       input logic [7:0] div, input logic [1:0] top,
                                       input logic [7:0] wl);
        return {4'b0, wl, 2'b0, top, div, 5'b0, sep, sp, st};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic pulse(input logic [31:0] active, input logic [31:0] idle);
        la_data_in = active;
        cycles(1);
        la_data_in = idle;
        cycles(1);
    endtask

    task automatic check_pads(input string tag);
        logic [37:0] e;
        e = '1;
        e[1:0] = 2'b00;
        check({tag, "_oeb"}, io_oeb, e);
        check({tag, "_out_hi"}, io_out[37:2], 36'd0);
    endtask

    initial begin
        logic [31:0] base;
        wb_rst_i   = 1'b1;
        la_oenb    = 32'hFFFF_FFFF;
        la_data_in = 32'd0;
        cycles(3);
        check("rst_la_out", la_data_out, 32'd0);
        check("rst_io_out", io_out, 38'd0);
        check_pads("rst");

        // 1: div=0, top=3, limit=1 -> 0,1,2,3,0 then DONE
        la_oenb    = 32'd0;
        base       = mk(0, 0, 0, 8'd0, 2'd3, 8'd1);
        la_data_in = base;
        cycles(1);
        wb_rst_i = 1'b0;
        cycles(1);
        la_data_in = mk(1, 0, 0, 8'd0, 2'd3, 8'd1);
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            if (i == 0) la_data_in = base;
            check("t1_seq", io_out[1:0], exp_q.pop_front());
        end
        check("t1_state", la_data_out[3:2], 2'd2);
        check("t1_done", la_data_out[4], 1'b1);
        check("t1_wrap", la_data_out[15:8], 8'd1);

        // 2: div=4 -> each value 5 cycles, free running, then stop freezes
        base       = mk(0, 0, 0, 8'd4, 2'd3, 8'd0);
        la_data_in = mk(1, 0, 0, 8'd4, 2'd3, 8'd0);
        for (int k = 1; k <= 47; k++) begin
            cycles(1);
            if (k == 1) la_data_in = base;
            check("t2_count", io_out[1:0], ((k - 1) / 5) % 4);
            if (k == 21) check("t2_wrap1", la_data_out[15:8], 8'd1);
            if (k == 41) check("t2_wrap2", la_data_out[15:8], 8'd2);
        end
        la_data_in = mk(0, 1, 0, 8'd4, 2'd3, 8'd0);
        cycles(1);
        check("t2_stop_state", la_data_out[3:2], 2'd0);
        la_data_in = base;
        cycles(10);
        check("t2_frozen", io_out[1:0], 2'd1);
        check("t2_wrap_kept", la_data_out[15:8], 8'd2);

        // 3: step to 3, then hold step 10 cycles -> one wrap to 0
        pulse(mk(0, 0, 1, 8'd4, 2'd3, 8'd0), base);
        pulse(mk(0, 0, 1, 8'd4, 2'd3, 8'd0), base);
        check("t3_pre", io_out[1:0], 2'd3);
        la_data_in = mk(0, 0, 1, 8'd4, 2'd3, 8'd0);
        cycles(10);
        check("t3_once", io_out[1:0], 2'd0);
        check("t3_wrap", la_data_out[15:8], 8'd2);
        check("t3_state", la_data_out[3:2], 2'd0);
        la_data_in = base;
        cycles(1);

        // 4: start+stop together in IDLE; then top changed mid-RUN is ignored
        pulse(mk(0, 0, 1, 8'd4, 2'd3, 8'd0), base);
        la_data_in = mk(1, 1, 0, 8'd0, 2'd3, 8'd0);
        cycles(3);
        check("t4_both_state", la_data_out[3:2], 2'd0);
        check("t4_both_count", io_out[1:0], 2'd1);
        la_data_in = mk(0, 0, 0, 8'd0, 2'd3, 8'd0);
        cycles(1);
        la_data_in = mk(1, 0, 0, 8'd0, 2'd3, 8'd0);
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            cycles(1);
            if (i == 0) la_data_in = mk(0, 0, 0, 8'd0, 2'd1, 8'd0);
            check("t4_latched_top", io_out[1:0], exp_q.pop_front());
        end
        la_data_in = mk(0, 1, 0, 8'd0, 2'd1, 8'd0);
        cycles(1);
        check("t4_stop_state", la_data_out[3:2], 2'd0);
        check("t4_stop_count", io_out[1:0], 2'd0);

        // 5: masked start is ignored; reset mid-RUN with start held high
        base    = mk(0, 0, 0, 8'd0, 2'd3, 8'd0);
        la_oenb = 32'h0000_0001;
        for (int i = 0; i < 6; i++) begin
            la_data_in = mk(i % 2, 0, 0, 8'd0, 2'd3, 8'd0);
            cycles(1);
            check("t5_masked", la_data_out[3:2], 2'd0);
        end
        la_data_in = base;
        la_oenb    = 32'd0;
        cycles(1);
        la_data_in = mk(1, 0, 0, 8'd0, 2'd3, 8'd0);
        cycles(3);
        check("t5_run", la_data_out[3:0], {2'd1, 2'd2});
        wb_rst_i = 1'b1;
        cycles(1);
        check("t5_rst_count", io_out[1:0], 2'd0);
        check("t5_rst_state", la_data_out[3:2], 2'd0);
        check_pads("t5_rst");
        cycles(1);
        wb_rst_i = 1'b0;
        cycles(5);
        check("t5_no_restart", la_data_out[3:0], 4'd0);
        la_data_in = base;
        cycles(1);

        // 6: reach DONE with div=2, top=1, limit=1, then restart from DONE
        base       = mk(0, 0, 0, 8'd2, 2'd1, 8'd1);
        la_data_in = mk(1, 0, 0, 8'd2, 2'd1, 8'd1);
        cycles(1);
        la_data_in = base;
        cycles(8);
        check("t6_done", la_data_out[4:0], {1'b1, 2'd2, 2'd0});
        la_data_in = mk(1, 0, 0, 8'd2, 2'd1, 8'd1);
        cycles(1);
        la_data_in = base;
        check("t6_restart", la_data_out[15:0], {8'd0, 3'd0, 1'b0, 2'd1, 2'd0});
        cycles(2);
        check("t6_hold", io_out[1:0], 2'd0);
        cycles(1);
        check("t6_first", io_out[1:0], 2'd1);
        check_pads("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
